// File: rtl/mbgd_theta_update.sv
// Theta update stage for mini-batch gradient descent: theta_j -= g_j >> alpha_shift
// per feature, then publishes the integer parts of all weights in a single cycle.
module mbgd_theta_update #(
    parameter int DW1   = 8,
    parameter int N     = 8,
    parameter int N_bit = 3,
    parameter int FRAC  = 8,
    parameter int EPW   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               start,
    input  logic               load_init,
    input  logic [DW1*N-1:0]   theta_init,
    input  logic [2:0]         alpha_shift,
    input  logic [EPW-1:0]     epoch_limit,
    input  logic [DW1-1:0]     g,
    input  logic               g_valid,
    output logic               g_ready,
    output logic [N_bit-1:0]   feat_idx,
    output logic [DW1*N-1:0]   theta,
    output logic               busy,
    output logic               upd_done,
    output logic [EPW-1:0]     epoch_cnt,
    output logic               limit_reached
);

    localparam int DWT = DW1 + FRAC;

    typedef enum logic [1:0] {IDLE, ACCEPT, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [N_bit-1:0]       j_q, j_d;
    logic [2:0]             alpha_q, alpha_d;
    logic signed [DWT-1:0]  theta_int_q [N];
    logic signed [DWT-1:0]  theta_int_d [N];
    logic [DW1*N-1:0]       theta_pub_q, theta_pub_d;
    logic [EPW-1:0]         epoch_q, epoch_d;
    logic                   limit_q, limit_d;

    logic signed [DWT:0]    g_ext;
    logic signed [DWT:0]    delta;
    logic signed [DWT:0]    diff;
    logic signed [DWT-1:0]  cur;
    logic signed [DWT-1:0]  sat_val;

    // Step is computed one bit wider than the weight so the clamp sees true overflow.
    always_comb begin
        g_ext = $signed({g[DW1-1], g, {FRAC{1'b0}}});
        delta = g_ext >>> alpha_q;
        cur   = theta_int_q[j_q];
        diff  = $signed({cur[DWT-1], cur}) - delta;
        if (diff[DWT] != diff[DWT-1]) begin
            sat_val = diff[DWT] ? {1'b1, {(DWT-1){1'b0}}} : {1'b0, {(DWT-1){1'b1}}};
        end else begin
            sat_val = diff[DWT-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        alpha_d     = alpha_q;
        theta_pub_d = theta_pub_q;
        epoch_d     = epoch_q;
        limit_d     = limit_q;
        for (int k = 0; k < N; k++) begin
            theta_int_d[k] = theta_int_q[k];
        end

        case (state_q)
            IDLE: begin
                if (enable && start) begin
                    alpha_d = alpha_shift;
                    j_d     = '0;
                    state_d = ACCEPT;
                    if (load_init) begin
                        for (int k = 0; k < N; k++) begin
                            theta_int_d[k] = {theta_init[DW1*k +: DW1], {FRAC{1'b0}}};
                        end
                    end
                end
            end
            ACCEPT: begin
                if (enable && g_valid) begin
                    theta_int_d[j_q] = sat_val;
                    if (j_q == N_bit'(N - 1)) begin
                        j_d     = '0;
                        state_d = COMMIT;
                    end else begin
                        j_d = j_q + N_bit'(1);
                    end
                end
            end
            COMMIT: begin
                if (enable) begin
                    for (int k = 0; k < N; k++) begin
                        theta_pub_d[DW1*k +: DW1] = theta_int_q[k][DWT-1:FRAC];
                    end
                    epoch_d = (&epoch_q) ? epoch_q : epoch_q + EPW'(1);
                    if ((epoch_d == epoch_limit) && (epoch_limit != '0)) begin
                        limit_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            j_q         <= '0;
            alpha_q     <= '0;
            theta_pub_q <= '0;
            epoch_q     <= '0;
            limit_q     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                theta_int_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            alpha_q     <= alpha_d;
            theta_pub_q <= theta_pub_d;
            epoch_q     <= epoch_d;
            limit_q     <= limit_d;
            for (int k = 0; k < N; k++) begin
                theta_int_q[k] <= theta_int_d[k];
            end
        end
    end

    assign g_ready       = (state_q == ACCEPT) && enable;
    assign feat_idx      = j_q;
    assign theta         = theta_pub_q;
    assign busy          = (state_q != IDLE);
    assign upd_done      = (state_q == COMMIT) && enable;
    assign epoch_cnt     = epoch_q;
    assign limit_reached = limit_q;

endmodule

// File: tb/tb_mbgd_theta_update.sv
// Directed bench for mbgd_theta_update; expected weights are worked out by hand
// from theta -= (g << 8) >>> alpha with saturation to 16 bits.
module tb_mbgd_theta_update;

    localparam int DW1 = 8;
    localparam int N   = 8;
    localparam int EPW = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               enable;
    logic               start;
    logic               load_init;
    logic [DW1*N-1:0]   theta_init;
    logic [2:0]         alpha_shift;
    logic [EPW-1:0]     epoch_limit;
    logic [DW1-1:0]     g;
    logic               g_valid;
    logic               g_ready;
    logic [2:0]         feat_idx;
    logic [DW1*N-1:0]   theta;
    logic               busy;
    logic               upd_done;
    logic [EPW-1:0]     epoch_cnt;
    logic               limit_reached;

    int vecCount  = 0;
    int missCount = 0;
    int doneCnt   = 0;

    mbgd_theta_update dut (
        .clk(clk), .resetn(resetn), .enable(enable), .start(start),
        .load_init(load_init), .theta_init(theta_init), .alpha_shift(alpha_shift),
        .epoch_limit(epoch_limit), .g(g), .g_valid(g_valid), .g_ready(g_ready),
        .feat_idx(feat_idx), .theta(theta), .busy(busy), .upd_done(upd_done),
        .epoch_cnt(epoch_cnt), .limit_reached(limit_reached)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd_done) doneCnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW1*N-1:0] fillTheta(input logic [7:0] v);
        logic [DW1*N-1:0] r;
        for (int k = 0; k < N; k++) r[DW1*k +: DW1] = v;
        return r;
    endfunction

    task automatic doReset();
        resetn  = 1'b0;
        start   = 1'b0;
        g_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // One full epoch with a constant gradient; returns with the bench idle after COMMIT.
    task automatic applyStimulus(input logic ld, input logic [DW1*N-1:0] init,
                                 input logic [2:0] alpha, input logic [7:0] gv);
        start       = 1'b1;
        load_init   = ld;
        theta_init  = init;
        alpha_shift = alpha;
        @(posedge clk); #1;
        start     = 1'b0;
        load_init = 1'b0;
        g         = gv;
        g_valid   = 1'b1;
        repeat (N) @(posedge clk);
        #1;
        g_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int idx;
        int d0;
        logic [DW1*N-1:0] expTheta;
        logic xfer;

        resetn = 1'b0; enable = 1'b1; start = 1'b0; load_init = 1'b0;
        theta_init = '0; alpha_shift = '0; epoch_limit = '0; g = '0; g_valid = 1'b0;
        #12;
        checkOutput("rst_theta", theta, 0);
        checkOutput("rst_epoch", epoch_cnt, 0);
        checkOutput("rst_g_ready", g_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_upd_done", upd_done, 0);
        checkOutput("rst_limit", limit_reached, 0);
        checkOutput("rst_feat_idx", feat_idx, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // basic: 16 - (8<<8 >>> 2)/256 = 14
        start = 1'b1; load_init = 1'b1; theta_init = fillTheta(8'd16); alpha_shift = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; load_init = 1'b0; g = 8'd8; g_valid = 1'b1;
        d0  = doneCnt;
        lat = 0;
        while (!upd_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        g_valid = 1'b0;
        checkOutput("basic_latency_edges", 64'(lat), 8);
        checkOutput("basic_theta_held", theta, 0);
        @(posedge clk); #1;
        checkOutput("basic_upd_pulses", 64'(doneCnt - d0), 1);
        checkOutput("basic_theta", theta, fillTheta(8'd14));
        checkOutput("basic_epoch", epoch_cnt, 1);
        checkOutput("basic_idle", busy, 0);

        // reset mid-epoch after three transfers
        start = 1'b1; alpha_shift = 3'd0;
        @(posedge clk); #1;
        start = 1'b0; g = 8'd1; g_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_theta", theta, 0);
        checkOutput("midrst_epoch", epoch_cnt, 0);
        checkOutput("midrst_g_ready", g_ready, 0);
        g_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // saturation both ways
        applyStimulus(1'b1, fillTheta(8'd127), 3'd0, 8'h80);
        checkOutput("sat_pos_theta", theta, fillTheta(8'h7f));
        applyStimulus(1'b1, fillTheta(8'h80), 3'd0, 8'd127);
        checkOutput("sat_neg_theta", theta, fillTheta(8'h80));
        checkOutput("sat_epoch", epoch_cnt, 2);

        // fractional accumulation: internal -2/256 per epoch
        doReset();
        applyStimulus(1'b1, '0, 3'd7, 8'd1);
        checkOutput("frac_ep1_theta", theta, fillTheta(8'hff));
        repeat (3) applyStimulus(1'b0, fillTheta(8'd99), 3'd7, 8'd1);
        checkOutput("frac_ep4_theta", theta, fillTheta(8'hff));
        checkOutput("frac_epoch", epoch_cnt, 4);

        // handshake stalls, enable drop and ignored start while busy
        doReset();
        start = 1'b1; load_init = 1'b1; theta_init = '0; alpha_shift = 3'd0;
        @(posedge clk); #1;
        start = 1'b0; load_init = 1'b0;
        idx = 0;
        d0  = doneCnt;
        for (int c = 0; c < 40 && idx < N; c++) begin
            enable  = !(c >= 6 && c < 11);
            g_valid = (c % 2) == 0;
            g       = 8'(idx + 1);
            if (c == 3) begin
                start = 1'b1; load_init = 1'b1; theta_init = fillTheta(8'd50);
            end else begin
                start = 1'b0; load_init = 1'b0;
            end
            #1;
            checkOutput($sformatf("stall_feat_idx_c%0d", c), feat_idx, 64'(idx));
            checkOutput($sformatf("stall_g_ready_c%0d", c), g_ready, enable ? 1 : 0);
            xfer = enable && g_valid;
            @(posedge clk); #1;
            if (xfer) idx++;
        end
        enable = 1'b1; start = 1'b0; load_init = 1'b0; g_valid = 1'b0;
        checkOutput("stall_transfers", 64'(idx), N);
        checkOutput("stall_commit_pulse", upd_done, 1);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) expTheta[DW1*k +: DW1] = 8'(0 - (k + 1));
        checkOutput("stall_theta", theta, expTheta);
        checkOutput("stall_upd_pulses", 64'(doneCnt - d0), 1);
        checkOutput("stall_epoch", epoch_cnt, 1);

        // epoch limit disabled
        doReset();
        epoch_limit = '0;
        applyStimulus(1'b1, '0, 3'd0, 8'd0);
        applyStimulus(1'b0, '0, 3'd0, 8'd0);
        checkOutput("limit0_flag", limit_reached, 0);

        // epoch limit 3
        doReset();
        epoch_limit = 16'd3;
        applyStimulus(1'b1, '0, 3'd0, 8'd0);
        applyStimulus(1'b0, '0, 3'd0, 8'd0);
        checkOutput("limit3_ep2_flag", limit_reached, 0);
        applyStimulus(1'b0, '0, 3'd0, 8'd0);
        checkOutput("limit3_ep3_flag", limit_reached, 1);
        applyStimulus(1'b0, '0, 3'd0, 8'd0);
        checkOutput("limit3_ep4_flag", limit_reached, 1);
        checkOutput("limit3_epoch", epoch_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
